serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial subtractor: computes DIFF = A - B, LSB first, one bit per clock. It uses a single half/full-subtractor cell and a registered borrow, the subtract-direction counterpart of the team's adder cells. It fits datapaths where area matters more than latency. Operands load on a START handshake; the result and final borrow are presented with a one-cycle DONE pulse.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
CLK     input   1      system clock, rising-edge.
RST_N   input   1      asynchronous active-low reset.
START   input   1      request; sampled only in IDLE.
A       input   WIDTH  minuend; captured on the accepted START edge.
B       input   WIDTH  subtrahend; captured on the accepted START edge.
BUSY    output  1      high while in SHIFT state.
DONE    output  1      one-cycle pulse; DIFF/BORROW valid from this cycle.
DIFF    output  WIDTH  A - B modulo 2^WIDTH, registered.
BORROW  output  1      final borrow-out; 1 when A < B (unsigned).

Behaviour:
- One clock domain (CLK). Reset is asynchronous, active-low (RST_N).
- Reset: state=IDLE, BUSY=0, DONE=0, DIFF=0, BORROW=0, internal shift registers, borrow flop and bit counter all cleared. Reset asserted mid-operation aborts immediately; no DONE is produced.
- States are IDLE, SHIFT and FIN.
- IDLE: at an edge with START=1, load A->sa and B->sb, clear the borrow flop, clear the counter, go to SHIFT. If START=0, stay in IDLE.
- SHIFT: each edge processes bit i = sa[0], sb[0], bin = borrow flop:
  - d = sa[0] ^ sb[0] ^ bin
  - bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin)
  - Shift sa and sb right by one; shift d into the MSB of the result register; borrow flop <= bout; count++.
- On the edge that processes bit WIDTH-1 (count == WIDTH-1):
  - DIFF <= the completed result register (including this bit).
  - BORROW <= bout.
  - DONE <= 1, go to FIN.
- FIN: DONE=1 for exactly this one cycle. The next edge clears DONE and returns to IDLE.
- Latency: START sampled at edge E; DONE is high in the cycle following edge E+WIDTH. BUSY is high for exactly WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- START in SHIFT or FIN is ignored: no reload, no effect on the in-flight operation. START held high continuously starts a new operation each time IDLE is reached.
- A and B are don't-care except at the accepted START edge.
- DIFF and BORROW hold their last result until the next DONE; they do not change during SHIFT.
- Arithmetic is unsigned, modulo 2^WIDTH. BORROW = 1 iff A < B. A == B gives DIFF=0, BORROW=0.
- Counter width is clog2(WIDTH), minimum 1; it never exceeds WIDTH-1.

Test Plan:
- WIDTH=8, A=5, B=3, START one cycle -> BUSY high 8 cycles, DONE pulse 1 cycle at E+9, DIFF=2, BORROW=0.
- A=3, B=5 -> DIFF=254, BORROW=1. A=0, B=1 -> DIFF=255, BORROW=1. A=200, B=200 -> DIFF=0, BORROW=0.
- A=0xAA, B=0x55 (alternating borrow paths) -> DIFF=0x55, BORROW=0. Also sweep all 65536 operand pairs against a reference model.
- Start A=10, B=4; pulse START with A=99, B=1 on cycle 3 of BUSY and again during FIN -> still DIFF=6, BORROW=0, exactly one DONE.
- Assert RST_N low during cycle 4 of SHIFT (asynchronously, mid-cycle) -> all outputs 0 immediately, no DONE. After release, A=7, B=9 -> DIFF=254, BORROW=1.
- START held high across two operations (A=1, B=2 then A=9, B=4) -> DONE pulses spaced 10 cycles apart, with results 255/1 then 5/0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, LSB first, one bit per clock,
// built around a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BORROW
);

   localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   // Full-subtractor cell; result is {borrow_out, difference_bit}.
   function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bin);
      logic d;
      logic bout;
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
      return {bout, d};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [1:0]       cell_s;

   // Next-state, datapath and output decode for the IDLE/SHIFT/FIN sequence.
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      cell_s   = sub_cell(sa_q[0], sb_q[0], brw_q);

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               sa_d    = A;
               sb_d    = B;
               brw_d   = 1'b0;
               cnt_d   = CNT_ZERO;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            res_d = {cell_s[0], res_q[WIDTH-1:1]};
            brw_d = cell_s[1];
            // The final bit publishes the finished word; the counter parks at its last value.
            if (cnt_q == LAST_BIT) begin
               diff_d   = res_d;
               borrow_d = cell_s[1];
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_FIN;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= CNT_ZERO;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign DIFF   = diff_q;
   assign BORROW = borrow_q;

endmodule
